// File: rtl/add32_pkg.sv
// ---------------------------------------------------------------------------
// add32_pkg
// Shared types for the adder result-capture slice.
//   ADD_W        : adder datapath width
//   add32_res_t  : one captured result {sum, carry, zero, neg, ovf}
//   add32_flags  : derives the status flags from a raw adder result
// ---------------------------------------------------------------------------
package add32_pkg;

    localparam int ADD_W = 32;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
    } add32_res_t;

    // Signed overflow: both operands share a sign and the sum's sign differs.
    function automatic add32_res_t add32_flags(
        input logic [ADD_W-1:0] sum,
        input logic             c32,
        input logic             a_msb,
        input logic             b_msb
    );
        add32_res_t r;
        r.sum   = sum;
        r.carry = c32;
        r.zero  = (sum == '0);
        r.neg   = sum[ADD_W-1];
        r.ovf   = (a_msb == b_msb) && (sum[ADD_W-1] != a_msb);
        return r;
    endfunction

endpackage

// File: rtl/add32_fifo.sv
// ---------------------------------------------------------------------------
// add32_fifo
// Synchronous DEPTH-entry FIFO of add32_res_t records.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write request (ignored while full)
//   wr_data    : record to write
//   rd_en      : read/pop request (ignored while empty)
//   rd_data    : head record, forced to zero while empty
//   full/empty : registered occupancy status
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module add32_fifo
    import add32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  add32_res_t wr_data,
    input  logic       rd_en,
    output add32_res_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    add32_res_t  mem [DEPTH];

    logic do_wr;
    logic do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only read
    // after it has been written, and rd_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/add32_result_buf.sv
// ---------------------------------------------------------------------------
// add32_result_buf
// Captures adder_32bit results with derived flags, queues them in a FIFO and
// hands them to a consumer over valid/ready. Keeps saturating event counters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : producer handshake (in_ready = not full)
//   in_sum, in_c32       : adder sum and carry-out
//   in_a_msb, in_b_msb   : operand sign bits used for signed overflow
//   out_valid / out_ready: consumer handshake (out_valid = not empty)
//   out_sum..out_ovf     : head entry data and flags (zero while empty)
//   clr_cnt              : synchronous clear of both counters (wins over +1)
//   carry_cnt, ovf_cnt   : saturating counts of accepted carry/overflow events
// ---------------------------------------------------------------------------
module add32_result_buf
    import add32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADD_W-1:0] in_sum,
    input  logic             in_c32,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADD_W-1:0] out_sum,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    add32_res_t in_res;
    add32_res_t head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;

    logic [CNT_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0] ovf_q,   ovf_d;

    assign in_res = add32_flags(in_sum, in_c32, in_a_msb, in_b_msb);

    // in_ready comes from registered occupancy only; a full FIFO never
    // accepts even if the consumer pops in the same cycle.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    add32_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (in_res),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign out_sum   = head.sum;
    assign out_carry = head.carry;
    assign out_zero  = head.zero;
    assign out_neg   = head.neg;
    assign out_ovf   = head.ovf;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (clr_cnt) begin
            carry_d = '0;
            ovf_d   = '0;
        end else if (push) begin
            if (in_res.carry && carry_q != CNT_MAX) carry_d = carry_q + CNT_ONE;
            if (in_res.ovf   && ovf_q   != CNT_MAX) ovf_d   = ovf_q   + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
            ovf_q   <= '0;
        end else begin
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign carry_cnt = carry_q;
    assign ovf_cnt   = ovf_q;

endmodule

// File: doc/add32_result_buf.md
# add32_result_buf

Result-capture stage placed directly downstream of `adder_32bit`. It latches each sum and carry-out together with the operand sign bits. It then derives status flags and queues the results in a small FIFO. Results leave the FIFO through a valid/ready handshake to the consumer. The block also keeps saturating event counters for carry-out and signed overflow, which software reads through status ports.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two and at least 2.
- `CNT_W`, default 8: width of each event counter.

Ports:
- `clk`, in, 1: single clock. Everything is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: the adder result on the `in_*` ports is valid.
- `in_ready`, out, 1: the block accepts the result this cycle.
- `in_sum`, in, 32: S from `adder_32bit`.
- `in_c32`, in, 1: C32 from `adder_32bit`.
- `in_a_msb`, in, 1: A[31] of the operands that produced `in_sum`.
- `in_b_msb`, in, 1: B[31] of the same operands.
- `out_valid`, out, 1: the FIFO head is valid.
- `out_ready`, in, 1: the consumer takes the head this cycle.
- `out_sum`, out, 32: head sum.
- `out_carry`, out, 1: head unsigned carry-out.
- `out_zero`, out, 1: head sum equals 0.
- `out_neg`, out, 1: head sum[31].
- `out_ovf`, out, 1: head signed overflow.
- `clr_cnt`, in, 1: synchronous clear of both counters.
- `carry_cnt`, out, CNT_W: count of accepted results with carry set.
- `ovf_cnt`, out, CNT_W: count of accepted results with overflow set.

## Operation
Push and pop:
- A push happens when `in_valid && in_ready`.
- A pop happens when `out_valid && out_ready`.

Flag derivation, evaluated at push time and stored with the entry:
- zero = (`in_sum` == 0)
- neg = `in_sum[31]`
- carry = `in_c32`
- ovf = (`in_a_msb` == `in_b_msb`) && (`in_sum[31]` != `in_a_msb`)

FIFO handshake:
- `in_ready` = !full. It depends only on registered occupancy, never on `out_ready` (no pop-through when full).
- `out_valid` = !empty. The `out_*` data ports are driven from the head entry.
- Push and pop in the same cycle leave occupancy unchanged. Both pointers advance modulo DEPTH.
- Push while full cannot occur because `in_ready` is low. Any `in_valid` asserted while full is held off and nothing is dropped.
- Pop while empty cannot occur because `out_valid` is low.
- While `out_valid && !out_ready`, the head data and flags stay stable.

Counters:
- On a push whose carry flag is set, `carry_cnt` increments by 1. On a push whose ovf flag is set, `ovf_cnt` increments by 1.
- Each counter saturates at 2^CNT_W−1.
- `clr_cnt` forces both counters to 0. If an increment arrives in the same cycle, the clear wins and the result is 0.

State:
- The only state is the occupancy pointers, the storage array and the counters. There is no FSM beyond the empty / partial / full status.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_sum`, `out_carry`, `out_zero`, `out_neg`, `out_ovf` = 0
  - `carry_cnt` = 0, `ovf_cnt` = 0
  - pointers = 0
- Latency: a result pushed at edge N is visible on `out_*`, with `out_valid` high, after edge N. There is no combinational path from `in_*` to `out_*`.
- `in_ready` drops the cycle after the DEPTH-th outstanding push. It rises the cycle after the next pop.
- Counter updates are visible one cycle after the push.
- If `rst_n` is asserted mid-stream, the queue empties immediately and the counters clear. No partially accepted entry survives. The first push after deassertion behaves as on an empty FIFO.
- Throughput: one push and one pop per cycle when the FIFO is neither full nor empty.

## Structure
- Package `add32_pkg` holds:
  - `ADD_W` = 32
  - a packed struct `add32_res_t` with fields {sum[31:0], carry, zero, neg, ovf}
  - a function `add32_flags(sum, c32, a_msb, b_msb)` that returns `add32_res_t`
- Sub-module `add32_fifo`: generic DEPTH×`add32_res_t` FIFO with full/empty outputs.
- The top level does flag derivation, the counters and the port mapping.

## Test plan
- **Single push, zero:** reset, then push `in_sum`=0x0000_0000, c32=0, a_msb=0, b_msb=0 with `out_ready`=1. Required: one cycle later `out_valid`=1, zero=1, neg=0, carry=0, ovf=0. The next cycle `out_valid`=0.
- **Signed overflow:** push sum=0x8000_0000 with a_msb=0, b_msb=0, c32=0. Required: ovf=1, neg=1, `ovf_cnt`=1. Then push sum=0x0000_0000 with a_msb=1, b_msb=1, c32=1. Required: ovf=1, carry=1, zero=1, `ovf_cnt`=2, `carry_cnt`=1.
- **Fill and drain:** hold `out_ready`=0 and push DEPTH (4) entries 1..4. Required: `in_ready`=0 after the 4th push, and a held 5th `in_valid` is not accepted. Then raise `out_ready`. Required: outputs appear in order 1,2,3,4, and `in_ready` returns to 1 the cycle after the first pop.
- **Simultaneous push/pop at occupancy 2:** required: occupancy stays 2, and the order is preserved across wrap-around over 3×DEPTH transfers with random `out_ready`.
- **Counter saturation and clear:** CNT_W=8, push 300 results with c32=1. Required: `carry_cnt`=255. Then assert `clr_cnt` in the same cycle as a carry push. Required: `carry_cnt`=0.
- **Reset mid-stream:** with 3 entries queued, pulse `rst_n` low asynchronously. Required: `out_valid`=0 and the counters read 0 immediately. The next push appears after 1 cycle with correct data.
